// File: rtl/cam_axis_packer.sv
// Packs a 16-bit pixel stream into 64-bit AXI-Stream words behind a first-word-fall-through FIFO.
// Define CAM_TEST_PATTERN_EN to let test_mode swap the pixel inputs for an internal index ramp.
module cam_axis_packer #(
    parameter int PIX_W      = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int CNT_W      = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             new_capture,
    input  logic [15:0]      image_width,
    input  logic [15:0]      image_height,
    input  logic [CNT_W-1:0] timeOut,
    input  logic             test_mode,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             camera_in_progress,
    output logic [CNT_W-1:0] dataXferedCnt,
    output logic             overflow,
    output logic             timeout_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      total_q, total_d, pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] idle_q, idle_d, xfer_q, xfer_d;
    logic [63:0]      asm_q, asm_d, push_data_q, push_data_d;
    logic [7:0]       push_keep_q, push_keep_d;
    logic             push_last_q, push_last_d, push_q, push_d;
    logic             ovf_q, ovf_d, tmo_q, tmo_d, cip_q, cip_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [72:0]      mem [FIFO_DEPTH];

    logic             src_valid, src_sof, accept, pop, push_ok;
    logic [PIX_W-1:0] src_data;
    logic [1:0]       slot;
    logic [31:0]      cnt_inc;
    logic [63:0]      word_w;

`ifdef CAM_TEST_PATTERN_EN
    logic [31:0] ramp_q, ramp_d;

    always_comb begin
        src_valid = pix_valid;
        src_sof   = pix_sof;
        src_data  = pix_data;
        if (test_mode) begin
            src_valid = (state_q == ARMED) || (state_q == CAPTURE);
            src_sof   = (ramp_q == 32'd0);
            src_data  = ramp_q[PIX_W-1:0];
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    always_comb begin
        src_valid = pix_valid;
        src_sof   = pix_sof;
        src_data  = pix_data;
    end
`endif

    // Number of filled slots in a word (0 means all four) to byte enables.
    function automatic logic [7:0] keep_for(input logic [1:0] n);
        case (n)
            2'd1:    keep_for = 8'h03;
            2'd2:    keep_for = 8'h0F;
            2'd3:    keep_for = 8'h3F;
            default: keep_for = 8'hFF;
        endcase
    endfunction

    assign m_axis_tvalid = (count_q != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok       = push_q && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr_q] : 73'd0;

    assign camera_in_progress = cip_q;
    assign dataXferedCnt      = xfer_q;
    assign overflow           = ovf_q;
    assign timeout_flag       = tmo_q;

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        pix_cnt_d   = pix_cnt_q;
        idle_d      = idle_q;
        xfer_d      = xfer_q;
        asm_d       = asm_q;
        push_data_d = push_data_q;
        push_keep_d = push_keep_q;
        push_last_d = push_last_q;
        push_d      = 1'b0;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        accept      = 1'b0;
        slot        = pix_cnt_q[1:0];
        cnt_inc     = pix_cnt_q + 32'd1;
        word_w      = asm_q;
        word_w[{slot, 4'b0000} +: 16] = src_data;
`ifdef CAM_TEST_PATTERN_EN
        ramp_d = ramp_q;
        if ((state_q == ARMED) || (state_q == CAPTURE))
            ramp_d = ramp_q + 32'd1;
`endif

        // Only the frame-closing word is worth retrying; dropped pixel words stay lost.
        if (push_q && !push_ok) begin
            ovf_d  = 1'b1;
            push_d = push_last_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            xfer_d   = xfer_q + CNT_W'($countones(m_axis_tkeep));
        end
        if (push_ok)
            wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

        unique case (state_q)
            IDLE: begin
                if (new_capture && (image_width != 16'd0) && (image_height != 16'd0)) begin
                    total_d   = 32'(image_width) * 32'(image_height);
                    xfer_d    = '0;
                    ovf_d     = 1'b0;
                    tmo_d     = 1'b0;
                    pix_cnt_d = '0;
                    idle_d    = '0;
                    asm_d     = '0;
                    state_d   = ARMED;
`ifdef CAM_TEST_PATTERN_EN
                    ramp_d    = '0;
`endif
                end
            end
            ARMED: begin
                if (src_valid && src_sof)
                    accept = 1'b1;
            end
            CAPTURE: begin
                if (src_valid) begin
                    accept = 1'b1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if ((timeOut != '0) && (idle_d == timeOut)) begin
                        push_d      = 1'b1;
                        push_last_d = 1'b1;
                        push_data_d = (slot == 2'd0) ? 64'd0 : asm_q;
                        push_keep_d = keep_for(slot);
                        tmo_d       = 1'b1;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            pix_cnt_d = cnt_inc;
            asm_d     = word_w;
            state_d   = CAPTURE;
            if (cnt_inc == total_q) begin
                push_d      = 1'b1;
                push_last_d = 1'b1;
                push_data_d = word_w;
                push_keep_d = keep_for(cnt_inc[1:0]);
                asm_d       = '0;
                state_d     = DRAIN;
            end else if (slot == 2'd3) begin
                push_d      = 1'b1;
                push_last_d = 1'b0;
                push_data_d = word_w;
                push_keep_d = 8'hFF;
                asm_d       = '0;
            end
        end

        cip_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            total_q     <= '0;
            pix_cnt_q   <= '0;
            idle_q      <= '0;
            xfer_q      <= '0;
            asm_q       <= '0;
            push_data_q <= '0;
            push_keep_q <= '0;
            push_last_q <= 1'b0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            cip_q       <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef CAM_TEST_PATTERN_EN
            ramp_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            pix_cnt_q   <= pix_cnt_d;
            idle_q      <= idle_d;
            xfer_q      <= xfer_d;
            asm_q       <= asm_d;
            push_data_q <= push_data_d;
            push_keep_q <= push_keep_d;
            push_last_q <= push_last_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            cip_q       <= cip_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef CAM_TEST_PATTERN_EN
            ramp_q      <= ramp_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= {push_last_q, push_keep_q, push_data_q};
    end
endmodule

// File: tb/tb_cam_axis_packer.sv
// Self-checking bench for cam_axis_packer: randomized frames against a word-list reference model.
module tb_cam_axis_packer;
    localparam int DEPTH = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        new_capture = 1'b0;
    logic [15:0] image_width = '0, image_height = '0;
    logic [31:0] timeOut = '0;
    logic        test_mode = 1'b0;
    logic        pix_valid = 1'b0, pix_sof = 1'b0;
    logic [15:0] pix_data = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        camera_in_progress;
    logic [31:0] dataXferedCnt;
    logic        overflow, timeout_flag;

    always #5 sys_clk = ~sys_clk;

    cam_axis_packer #(.PIX_W(16), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .new_capture(new_capture),
        .image_width(image_width), .image_height(image_height), .timeOut(timeOut),
        .test_mode(test_mode), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .camera_in_progress(camera_in_progress), .dataXferedCnt(dataXferedCnt),
        .overflow(overflow), .timeout_flag(timeout_flag)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    bit          rnd_ready = 1'b0;
    logic [15:0] acc_px[$];
    logic [72:0] got_q[$];
    logic [72:0] exp_q[$];
    logic [72:0] stall_word;
    bit          stalled = 1'b0;

    // Output monitor: records handshakes and checks that a stalled word is held.
    always @(negedge sys_clk) begin
        if (stalled && !sys_rst) begin
            n_tests++;
            if (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== stall_word) begin
                n_fail++;
                $display("FAIL axis_hold: got valid=%b word=%h required valid=1 word=%h",
                         m_axis_tvalid, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, stall_word);
            end
        end
        stalled    = m_axis_tvalid && !m_axis_tready && !sys_rst;
        stall_word = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready && !sys_rst) begin
            got_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            $display("[TB] beat data=%h keep=%h last=%b", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 3 ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (rnd_ready)
            m_axis_tready = m_axis_tready ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    function automatic logic [72:0] make_word(input int start, input int k, input bit last);
        logic [63:0] d = '0;
        logic [7:0]  keep = '0;
        for (int s = 0; s < k; s++) begin
            d[s*16 +: 16] = acc_px[start + s];
            keep[2*s +: 2] = 2'b11;
        end
        return {last, keep, d};
    endfunction

    // Expected words: accepted pixels in groups of four, last group closes the frame;
    // a timeout on a word boundary adds an all-zero full word as the closing beat.
    function automatic void build_model(input bit tmo);
        int n = acc_px.size();
        exp_q.delete();
        for (int st = 0; st < n; st += 4) begin
            int k = (n - st >= 4) ? 4 : n - st;
            exp_q.push_back(make_word(st, k, (st + k == n) && (!tmo || k < 4)));
        end
        if (tmo && (n % 4 == 0))
            exp_q.push_back({1'b1, 8'hFF, 64'd0});
    endfunction

    task automatic run_frame(input int w, input int h, input int npix, input int junk,
                             input bit gaps, input bit ramp);
        int total = w * h;
        logic [15:0] d;
        acc_px.delete();
        got_q.delete();
        image_width = 16'(w);
        image_height = 16'(h);
        new_capture = 1'b1;
        tick();
        new_capture = 1'b0;
        for (int j = 0; j < junk; j++) begin
            pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 16'($urandom);
            tick();
        end
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int c = 0; c < g; c++) begin
                    pix_valid = 1'b0;
                    tick();
                end
            end
            d = ramp ? 16'(i) : 16'($urandom);
            pix_valid = 1'b1;
            pix_sof = (i == 0) || ($urandom_range(0, 9) == 0);
            pix_data = d;
            new_capture = (i == total - 1);
            image_width = 16'(w + 1);
            if (i < total) acc_px.push_back(d);
            tick();
            new_capture = 1'b0;
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int c = 0;
        while (camera_in_progress && c < maxc) begin
            tick();
            c++;
        end
        n_tests++;
        if (camera_in_progress) begin
            n_fail++;
            $display("FAIL %s_done: camera_in_progress=%b after %0d cycles, required 0", name, camera_in_progress, c);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_axis: got %h required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end
        n_tests++;
        if ({camera_in_progress, overflow, timeout_flag} !== 3'b000 || dataXferedCnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status: got cip/ovf/tmo=%b cnt=%0d required 000 and 0",
                     {camera_in_progress, overflow, timeout_flag}, dataXferedCnt);
        end
    endtask

    task automatic test_t1();
        run_frame(4, 2, 8, 0, 0, 1);
        n_tests++;
        if (camera_in_progress !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy: got %b required 1", camera_in_progress);
        end
        wait_idle(200, "t1");
        build_model(1'b0);
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 8'hFF, 64'h0003_0002_0001_0000} || got_q[1][72] !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_words: got %0d words first=%h required 2 words first=%h with tlast on second",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 73'd0, {1'b0, 8'hFF, 64'h0003_0002_0001_0000});
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL t1_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (dataXferedCnt !== 32'd16) begin
            n_fail++;
            $display("FAIL t1_bytes: got %0d required 16", dataXferedCnt);
        end
    endtask

    task automatic test_t2();
        run_frame(3, 1, 3, 1, 0, 0);
        wait_idle(200, "t2");
        n_tests++;
        if (got_q.size() != 1 || got_q[0][72:64] !== {1'b1, 8'h3F}) begin
            n_fail++;
            $display("FAIL t2_word: got %0d words last/keep=%h required 1 word last/keep=13f",
                     got_q.size(), (got_q.size() > 0) ? got_q[0][72:64] : 9'd0);
        end
        n_tests++;
        if (dataXferedCnt !== 32'd6) begin
            n_fail++;
            $display("FAIL t2_bytes: got %0d required 6", dataXferedCnt);
        end
    endtask

    task automatic test_random();
        rnd_ready = 1'b1;
        timeOut = 32'd0;
        for (int f = 0; f < 10; f++) begin
            int w = $urandom_range(1, 6);
            int h = $urandom_range(1, 3);
            run_frame(w, h, w * h + $urandom_range(0, 2), $urandom_range(0, 3), 1, 0);
            wait_idle(500, "rand");
            build_model(1'b0);
            n_tests++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d words required %0d", f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got %h required %h", f, i, got_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (dataXferedCnt !== 32'(2 * w * h) || overflow !== 1'b0 || timeout_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: got cnt=%0d ovf=%b tmo=%b required cnt=%0d ovf=0 tmo=0",
                         f, dataXferedCnt, overflow, timeout_flag, 2 * w * h);
            end
        end
        rnd_ready = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_ignored_capture();
        image_width = 16'd0; image_height = 16'd5; new_capture = 1'b1;
        tick();
        new_capture = 1'b0;
        tick();
        n_tests++;
        if (camera_in_progress !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_width: got cip=%b required 0", camera_in_progress);
        end
        image_width = 16'd5; image_height = 16'd0; new_capture = 1'b1;
        tick();
        new_capture = 1'b0;
        tick();
        n_tests++;
        if (camera_in_progress !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_height: got cip=%b required 0", camera_in_progress);
        end
    endtask

    task automatic test_timeout();
        timeOut = 32'd10;
        acc_px.delete();
        got_q.delete();
        image_width = 16'd8; image_height = 16'd1; new_capture = 1'b1;
        tick();
        new_capture = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1; pix_sof = (i == 0); pix_data = 16'($urandom);
            acc_px.push_back(pix_data);
            tick();
        end
        pix_valid = 1'b0; pix_sof = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || timeout_flag !== 1'b0 || camera_in_progress !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: after 9 idle got valid=%b tmo=%b cip=%b required 0 0 1",
                     m_axis_tvalid, timeout_flag, camera_in_progress);
        end
        tick();
        n_tests++;
        if (timeout_flag !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_flag: after 10 idle got tmo=%b valid=%b required 1 0", timeout_flag, m_axis_tvalid);
        end
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tkeep !== 8'h03) begin
            n_fail++;
            $display("FAIL tmo_word: got valid=%b last=%b keep=%h required 1 1 03",
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
        end
        wait_idle(100, "tmo");
        build_model(1'b1);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL tmo_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL tmo_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (dataXferedCnt !== 32'd10) begin
            n_fail++;
            $display("FAIL tmo_bytes: got %0d required 10", dataXferedCnt);
        end
        // Timeout on a word boundary closes the frame with a zero full word.
        timeOut = 32'd3;
        run_frame(8, 1, 4, 0, 0, 0);
        wait_idle(100, "tmo0");
        build_model(1'b1);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL tmo0_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL tmo0_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (dataXferedCnt !== 32'd16 || timeout_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo0_status: got cnt=%0d tmo=%b required 16 1", dataXferedCnt, timeout_flag);
        end
        timeOut = 32'd0;
    endtask

    task automatic test_overflow();
        m_axis_tready = 1'b0;
        run_frame(4, 8, 32, 0, 0, 0);
        for (int c = 0; c < 10; c++) tick();
        n_tests++;
        if (overflow !== 1'b1 || camera_in_progress !== 1'b1 || m_axis_tvalid !== 1'b1 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_stall: got ovf=%b cip=%b valid=%b beats=%0d required 1 1 1 0",
                     overflow, camera_in_progress, m_axis_tvalid, got_q.size());
        end
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(make_word(4 * i, 4, 1'b0));
        exp_q.push_back(make_word(28, 4, 1'b1));
        m_axis_tready = 1'b1;
        wait_idle(100, "ovf");
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (dataXferedCnt !== 32'(8 * (DEPTH + 1)) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_status: got cnt=%0d ovf=%b required %0d 1", dataXferedCnt, overflow, 8 * (DEPTH + 1));
        end
    endtask

    task automatic test_reset_midframe();
        m_axis_tready = 1'b0;
        run_frame(4, 4, 12, 0, 0, 0);
        for (int c = 0; c < 3; c++) tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: got valid=%b ovf=%b required 1 0", m_axis_tvalid, overflow);
        end
        sys_rst = 1'b1;
        tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || camera_in_progress !== 1'b0 || dataXferedCnt !== 32'd0 || timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b cip=%b cnt=%0d tmo=%b required 0 0 0 0",
                     m_axis_tvalid, camera_in_progress, dataXferedCnt, timeout_flag);
        end
        tick();
        sys_rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        run_frame(4, 2, 8, 0, 0, 0);
        wait_idle(200, "rst_after");
        build_model(1'b0);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rst_after_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_after_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (dataXferedCnt !== 32'd16) begin
            n_fail++;
            $display("FAIL rst_after_bytes: got %0d required 16", dataXferedCnt);
        end
    endtask

    task automatic test_pattern();
`ifdef CAM_TEST_PATTERN_EN
        test_mode = 1'b1;
        got_q.delete();
        image_width = 16'd8; image_height = 16'd1; new_capture = 1'b1;
        tick();
        new_capture = 1'b0;
        wait_idle(100, "ramp");
        test_mode = 1'b0;
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 8'hFF, 64'h0003_0002_0001_0000}
            || got_q[1] !== {1'b1, 8'hFF, 64'h0007_0006_0005_0004}) begin
            n_fail++;
            $display("FAIL ramp_words: got %0d words first=%h required 2 words 0003000200010000/0007000600050004",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 73'd0);
        end
`else
        test_mode = 1'b1;
        run_frame(5, 1, 5, 1, 0, 0);
        wait_idle(100, "mode_ignored");
        test_mode = 1'b0;
        build_model(1'b0);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mode_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
`endif
        n_tests++;
        if (dataXferedCnt !== 32'(2 * acc_px.size()) && dataXferedCnt !== 32'd16) begin
            n_fail++;
            $display("FAIL mode_bytes: got %0d required %0d", dataXferedCnt, 2 * acc_px.size());
        end
    endtask

    initial begin
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        test_reset();
        test_t1();
        test_t2();
        test_random();
        test_ignored_capture();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        test_pattern();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
